// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the shared memory port of the data-memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if;
   logic        a_req;
   logic        a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic        a_ack;
   logic        a_err;
   logic [31:0] a_rdata;

   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_ack;
   logic        b_err;
   logic [31:0] b_rdata;

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_err, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_err, b_rdata,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_err, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_err, b_rdata,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE->ACCESS->RESP, ack two cycles after the req sample, 1 txn per 3 cycles.
// One transaction in flight; the losing port simply keeps req high until it is granted in a later IDLE.
module dmem_arbiter #(
   parameter int MEM_BYTES  = 64,
   parameter int FIXED_PRIO = 0
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);
   localparam logic        PORT_A   = 1'b0;
   localparam logic        PORT_B   = 1'b1;

   state_t      state, next_state;
   logic        last_grant;
   logic        gnt_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] a_rdata_q;
   logic [31:0] b_rdata_q;

   logic        any_req;
   logic        grant_b;
   logic [31:0] req_addr;
   logic        req_err;

   always_comb begin
      any_req  = bus.a_req | bus.b_req;
      // B wins if alone, or on a tie when round-robin and A went last.
      grant_b  = bus.b_req & (~bus.a_req | ((FIXED_PRIO == 0) & (last_grant == PORT_A)));
      req_addr = grant_b ? bus.b_addr : bus.a_addr;
      req_err  = (req_addr[1:0] != 2'b00) | (req_addr > MAX_ADDR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.a_ack     = 1'b0;
      bus.b_ack     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) next_state = ACCESS;
         end
         ACCESS: begin
            bus.mem_we    = we_q & ~err_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
            next_state    = RESP;
         end
         RESP: begin
            bus.a_ack  = (gnt_q == PORT_A);
            bus.b_ack  = (gnt_q == PORT_B);
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign bus.a_err   = bus.a_ack & err_q;
   assign bus.b_err   = bus.b_ack & err_q;
   assign bus.a_rdata = a_rdata_q;
   assign bus.b_rdata = b_rdata_q;
   assign bus.busy    = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_B;
         gnt_q      <= PORT_A;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         a_rdata_q  <= 32'h0;
         b_rdata_q  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_q      <= grant_b;
                  last_grant <= grant_b;
                  we_q       <= grant_b ? bus.b_we    : bus.a_we;
                  wdata_q    <= grant_b ? bus.b_wdata : bus.a_wdata;
                  addr_q     <= req_addr;
                  err_q      <= req_err;
               end
            end
            ACCESS: begin
               // Capturing straight into the per-port register keeps the other port's data intact.
               if (gnt_q == PORT_B) begin
                  b_rdata_q <= err_q ? 32'h0 : bus.mem_rdata;
               end else begin
                  a_rdata_q <= err_q ? 32'h0 : bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
